// File: rtl/kbd_pkg.sv
// Shared types and widths for the keypad event path.
package kbd_pkg;

    localparam int unsigned KEY_W  = 16;
    localparam int unsigned CODE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT,
        ST_LOCK
    } state_t;

    typedef enum logic [1:0] {
        KC_NONE,
        KC_SINGLE,
        KC_MULTI
    } kcls_t;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              rpt;
    } ev_t;

    function automatic logic [KEY_W-1:0] onehot(input logic [CODE_W-1:0] c);
        return KEY_W'(1) << c;
    endfunction

endpackage

// File: rtl/key_onehot_enc.sv
// Classifies the debounced key vector as none / single / multi and reports
// the index of the pressed key.
module key_onehot_enc
    import kbd_pkg::*;
(
    input  logic [KEY_W-1:0]  key_deb,
    output kcls_t             kcls,
    output logic [CODE_W-1:0] key_idx
);

    logic [KEY_W-1:0] low_cleared;

    // Clearing the lowest set bit leaves zero only for a single key.
    assign low_cleared = key_deb & (key_deb - KEY_W'(1));

    always_comb begin
        kcls = KC_NONE;
        if (key_deb == '0) begin
            kcls = KC_NONE;
        end else if (low_cleared == '0) begin
            kcls = KC_SINGLE;
        end else begin
            kcls = KC_MULTI;
        end
    end

    always_comb begin
        key_idx = '0;
        for (int unsigned i = 0; i < KEY_W; i++) begin
            if (key_deb[i]) begin
                key_idx = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/key_event_gen.sv
// Turns debounced key levels into press / auto-repeat events, rejects chords,
// and hands events out through a one-entry valid/ready buffer.
module key_event_gen
    import kbd_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned DELAY_MS = 500,
    parameter int unsigned RATE_MS  = 100
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [KEY_W-1:0]  key_deb,
    input  logic              ev_ready,
    output logic              ev_valid,
    output logic [CODE_W-1:0] ev_code,
    output logic              ev_repeat,
    output logic              ev_drop,
    output logic              multi_key
);

    localparam int unsigned DELAY_CYC  = CLK_HZ / 1000 * DELAY_MS;
    localparam int unsigned RATE_CYC   = CLK_HZ / 1000 * RATE_MS;
    localparam logic [31:0] DELAY_LAST = DELAY_CYC - 1;
    localparam logic [31:0] RATE_LAST  = RATE_CYC - 1;

    kcls_t             kcls;
    logic [CODE_W-1:0] key_idx;

    state_t            state, state_nx;
    logic [31:0]       cnt, cnt_nx;
    logic [CODE_W-1:0] cur, cur_nx;
    logic              emit;
    ev_t               emit_ev;
    ev_t               ev_buf;
    logic              held_same;

    key_onehot_enc u_enc (
        .key_deb (key_deb),
        .kcls    (kcls),
        .key_idx (key_idx)
    );

    assign held_same = (key_deb == onehot(cur));

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            cnt   <= '0;
            cur   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            cur   <= cur_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        cur_nx       = cur;
        emit         = 1'b0;
        emit_ev.code = cur;
        emit_ev.rpt  = 1'b1;
        case (state)
            ST_IDLE: begin
                if (kcls == KC_SINGLE) begin
                    emit         = 1'b1;
                    emit_ev.code = key_idx;
                    emit_ev.rpt  = 1'b0;
                    cur_nx       = key_idx;
                    cnt_nx       = '0;
                    state_nx     = ST_HOLD;
                end else if (kcls == KC_MULTI) begin
                    cnt_nx   = '0;
                    state_nx = ST_LOCK;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (held_same) begin
                    if (cnt == ((state == ST_HOLD) ? DELAY_LAST : RATE_LAST)) begin
                        emit     = 1'b1;
                        cnt_nx   = '0;
                        state_nx = ST_REPEAT;
                    end else begin
                        cnt_nx = cnt + 32'd1;
                    end
                end else if (kcls == KC_NONE) begin
                    cnt_nx   = '0;
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx   = '0;
                    state_nx = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (kcls == KC_NONE) begin
                    cnt_nx   = '0;
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = ST_IDLE;
            end
        endcase
    end

    // A new event may replace the pending one only in the cycle it is accepted.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            ev_buf   <= '0;
            ev_valid <= 1'b0;
            ev_drop  <= 1'b0;
        end else begin
            ev_drop <= 1'b0;
            if (emit) begin
                if (!ev_valid || ev_ready) begin
                    ev_buf   <= emit_ev;
                    ev_valid <= 1'b1;
                end else begin
                    ev_drop <= 1'b1;
                end
            end else if (ev_valid && ev_ready) begin
                ev_valid <= 1'b0;
            end
        end
    end

    assign ev_code   = ev_buf.code;
    assign ev_repeat = ev_buf.rpt;
    assign multi_key = (state == ST_LOCK);

endmodule

// File: tb/tb_key_event_gen.sv
// Directed vector bench for key_event_gen with DELAY_CYC=5, RATE_CYC=2.
module tb_key_event_gen;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] key_deb = '0;
    logic        ev_ready = 1'b1;
    logic        ev_valid;
    logic [3:0]  ev_code;
    logic        ev_repeat;
    logic        ev_drop;
    logic        multi_key;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        rst;
        logic [15:0] key;
        logic        ready;
        logic        v;
        logic [3:0]  code;
        logic        rpt;
        logic        drop;
        logic        mk;
    } vec_t;

    vec_t vecs[$];

    key_event_gen #(
        .CLK_HZ   (1000),
        .DELAY_MS (5),
        .RATE_MS  (2)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .key_deb   (key_deb),
        .ev_ready  (ev_ready),
        .ev_valid  (ev_valid),
        .ev_code   (ev_code),
        .ev_repeat (ev_repeat),
        .ev_drop   (ev_drop),
        .multi_key (multi_key)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic rst, input logic [15:0] key, input logic ready,
                                input logic v, input logic [3:0] code, input logic rpt,
                                input logic drop, input logic mk);
        vec_t r;
        r.rst = rst; r.key = key; r.ready = ready; r.v = v;
        r.code = code; r.rpt = rpt; r.drop = drop; r.mk = mk;
        vecs.push_back(r);
    endfunction

    // code/repeat are only meaningful while valid unless full_cmp is set
    task automatic check(input string name, input logic v, input logic [3:0] code,
                         input logic rpt, input logic drop, input logic mk,
                         input logic full_cmp);
        logic [7:0] act, exp;
        act = {ev_valid, ev_code, ev_repeat, ev_drop, multi_key};
        exp = {v, code, rpt, drop, mk};
        if (!v && !full_cmp) begin
            act[6:2] = '0;
            exp[6:2] = '0;
        end
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got v=%b code=%0d rpt=%b drop=%b mk=%b, want v=%b code=%0d rpt=%b drop=%b mk=%b",
                     name, ev_valid, ev_code, ev_repeat, ev_drop, multi_key,
                     v, code, rpt, drop, mk);
        end
    endtask

    initial begin
        // Each row: inputs applied before an edge, outputs expected just after it.
        // reset
        add(1, 16'h0000, 1, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 0, 0, 0);
        // tap key 3
        add(0, 16'h0008, 1, 1, 3, 0, 0, 0);
        add(0, 16'h0008, 1, 0, 0, 0, 0, 0);
        add(0, 16'h0008, 1, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 0, 0, 0);
        // hold key 15 for 12 cycles
        add(0, 16'h8000, 1, 1, 15, 0, 0, 0);
        for (int i = 1; i < 12; i++) begin
            if (i == 5 || i == 7 || i == 9 || i == 11)
                add(0, 16'h8000, 1, 1, 15, 1, 0, 0);
            else
                add(0, 16'h8000, 1, 0, 0, 0, 0, 0);
        end
        add(0, 16'h0000, 1, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 0, 0, 0);
        // chord 0 then 0+1
        add(0, 16'h0001, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 16'h0003, 1, 0, 0, 0, 0, 1);
        add(0, 16'h0000, 1, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 0, 0, 0);
        // backpressure on key 5
        for (int i = 0; i < 8; i++)
            add(0, 16'h0020, 0, 1, 5, 0, (i == 5 || i == 7) ? 1'b1 : 1'b0, 0);
        add(0, 16'h0000, 1, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 0, 0, 0);
        // accept and emit in the same cycle on key 2
        for (int i = 0; i < 5; i++) add(0, 16'h0004, 0, 1, 2, 0, 0, 0);
        add(0, 16'h0004, 1, 1, 2, 1, 0, 0);
        add(0, 16'h0004, 1, 0, 0, 0, 0, 0);
        add(0, 16'h0004, 1, 1, 2, 1, 0, 0);
        add(0, 16'h0004, 0, 1, 2, 1, 0, 0);

        foreach (vecs[i]) begin
            RST      = vecs[i].rst;
            key_deb  = vecs[i].key;
            ev_ready = vecs[i].ready;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].v, vecs[i].code, vecs[i].rpt,
                  vecs[i].drop, vecs[i].mk, 1'b0);
        end

        // asynchronous reset mid-REPEAT with an event pending
        #2;
        RST = 1'b1;
        #1;
        check("async_rst", 0, 0, 0, 0, 0, 1'b1);
        @(posedge clk);
        #1;
        check("rst_held", 0, 0, 0, 0, 0, 1'b1);
        RST      = 1'b0;
        ev_ready = 1'b1;
        @(posedge clk);
        #1;
        check("press_after_rst", 1, 2, 0, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        check("accepted_after_rst", 0, 0, 0, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_event_gen.md
# key_event_gen

Converts the debounced 16-key vector from `key_filter` into discrete key events: one press event per key-down, plus auto-repeat events while a single key is held. Sits between `key_filter` and the game/decoder logic that drives the display and buzzer. Rejects multi-key chords and delivers each event through a one-entry valid/ready output buffer.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, clock frequency in Hz.
- `DELAY_MS`, 500, hold time before the first repeat event.
- `RATE_MS`, 100, interval between subsequent repeat events.

Ports:
- `clk`  input  1  system clock (50 MHz board clock).
- `RST`  input  1  asynchronous, active-high reset.
- `key_deb`  input  16  debounced key levels, bit i = 1 while key i is pressed.
- `ev_ready`  input  1  consumer accepts the event this cycle.
- `ev_valid`  output  1  event pending.
- `ev_code`  output  4  key index 0..15 of the pending event.
- `ev_repeat`  output  1  0 = initial press, 1 = auto-repeat.
- `ev_drop`  output  1  one-cycle pulse when an event is lost because the buffer is full.
- `multi_key`  output  1  high while the block is in LOCK.

## Operation
- Derived constants: `DELAY_CYC = CLK_HZ/1000*DELAY_MS`, `RATE_CYC = CLK_HZ/1000*RATE_MS`, both ≥ 2. Counter is 32 bits, unsigned, and cleared on every state entry.
- Classification of `key_deb`: NONE (all 0), SINGLE (exactly one bit set, index k), MULTI (two or more bits set).
- FSM states: IDLE, HOLD, REPEAT, LOCK. Latched key index `cur`.
- IDLE:
  - SINGLE → emit press (code k, repeat 0), latch `cur`=k, go to HOLD.
  - MULTI → LOCK.
  - NONE → stay.
- HOLD:
  - `key_deb` equal to onehot(`cur`) → count. When the count reaches `DELAY_CYC-1`, emit a repeat event and go to REPEAT.
  - NONE → IDLE.
  - Any other value → LOCK, no event.
- REPEAT: same as HOLD, but uses `RATE_CYC` and stays in REPEAT, emitting a repeat event every `RATE_CYC` cycles.
- LOCK: no events. Leaves only on NONE, going to IDLE.
- Output buffer (one entry):
  - An emit loads code/repeat and sets `ev_valid`.
  - `ev_valid && ev_ready` clears the buffer, unless an emit occurs in the same cycle; in that case the new event is loaded and `ev_valid` stays 1.
  - An emit while `ev_valid && !ev_ready` keeps the old event, discards the new one, and pulses `ev_drop`.
  - `ev_code`/`ev_repeat` are stable while `ev_valid` is high and unaccepted.

## Timing
- Reset values: state IDLE, counter 0, `ev_valid` 0, `ev_code` 0, `ev_repeat` 0, `ev_drop` 0, `multi_key` 0.
- Reset acts asynchronously, including mid-hold or with an event pending; the pending event is discarded.
- Press latency: `key_deb` becomes SINGLE in cycle t → `ev_valid`=1 in cycle t+1 (registered).
- First repeat: `ev_valid` rises `DELAY_CYC` cycles after the press event's `ev_valid`. Later repeats follow every `RATE_CYC` cycles.
- `multi_key` rises one cycle after entering LOCK conditions and falls one cycle after NONE is seen.
- Release followed by a new SINGLE in the next cycle: IDLE sees it and produces a press event. At least one NONE cycle is required between presses.
- Inputs come from `key_filter` in the same clock domain, so no extra synchroniser is needed.

## Structure
- Package `kbd_pkg` holds:
  - `KEY_W`=16 and `CODE_W`=4
  - FSM state enum
  - `ev_t` (code, repeat)
- Sub-module `key_onehot_enc`: combinational; classifies `key_deb` (NONE/SINGLE/MULTI) and produces the index k.
- The top contains the FSM, the counter and the output buffer.

## Test plan
All scenarios use `CLK_HZ`=1000, `DELAY_MS`=5, `RATE_MS`=2, giving `DELAY_CYC`=5 and `RATE_CYC`=2. `ev_ready` is tied to 1 unless stated otherwise.
- Tap: `key_deb`=16'h0008 for 3 cycles, then 0 → exactly one event (code 3, repeat 0), one cycle after the input rises; no repeats.
- Hold: `key_deb`=16'h8000 for 12 cycles → press (code 15) at t+1; repeat events (code 15, repeat 1) at t+6, t+8, t+10, t+12.
- Chord: 16'h0001, then 16'h0003 in the next cycle, held 10 cycles, then 0 → one press (code 0) only; `multi_key`=1 until one cycle after release; no repeat.
- Backpressure: `ev_ready`=0, hold 16'h0020 for 8 cycles → `ev_valid` stays with code 5, repeat 0; `ev_drop` pulses on the repeat at t+6. After raising `ev_ready` → one handshake, then `ev_valid`=0.
- Accept+emit same cycle: pending press accepted in the same cycle a repeat is emitted → `ev_valid` stays 1 with repeat=1; `ev_drop` not asserted.
- Reset: assert `RST` mid-REPEAT with an event pending → all outputs 0 immediately. After release with the key still held → treated as a new press (code unchanged, repeat 0).
